controller_status_pio_capture: RTL

CONTROLLER_STATUS_PIO_CAPTURE -- requirements
Module: controller_status_pio_capture

---
 rtl/controller_status_pio_capture.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/controller_status_pio_capture.sv
// Status PIO capture block with an Avalon-MM slave interface.
// Asynchronous status inputs are synchronised, optionally debounced, and
// edge-detected. Edges are latched in a write-1-to-clear register and
// combined with an interrupt mask to form a level interrupt.
module controller_status_pio_capture #(
  parameter int WIDTH       = 10,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 0,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] EDGE_SEL = EDGE_TYPE[1:0];

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_s;
  logic [WIDTH-1:0] filt_s;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] det_s;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_d;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic             wr_s;
  logic             unused_s;

  assign wr_s     = chipselect & ~write_n;
  assign sync_s   = sync_q[SYNC_STAGES-1];
  // writedata bits above WIDTH are intentionally ignored by every register
  assign unused_s = ^writedata;

  // Multi-flop synchroniser chain per input bit
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= {WIDTH{1'b0}};
      end
    end else begin
      sync_q[0] <= in_port;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  generate
    if (DEBOUNCE == 0) begin : g_bypass
      // No debounce: the filtered value is the synchroniser output directly
      assign filt_s = sync_s;
    end else begin : g_debounce
      localparam logic [15:0] LAST_CNT = 16'(DEBOUNCE - 1);
      logic [15:0]      cnt_q [WIDTH];
      logic [WIDTH-1:0] filt_q;

      // Per-bit stability counter; filt follows sync only after DEBOUNCE
      // consecutive cycles of disagreement
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          filt_q <= {WIDTH{1'b0}};
          for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= 16'd0;
          end
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (sync_s[i] == filt_q[i]) begin
              cnt_q[i] <= 16'd0;
            end else if (cnt_q[i] == LAST_CNT) begin
              filt_q[i] <= sync_s[i];
              cnt_q[i]  <= 16'd0;
            end else begin
              cnt_q[i] <= cnt_q[i] + 16'd1;
            end
          end
        end
      end

      assign filt_s = filt_q;
    end
  endgenerate

  // Edge detect on the filtered value against its one-cycle-old copy
  always_comb begin
    det_s = {WIDTH{1'b0}};
    case (EDGE_SEL)
      2'd0:    det_s = filt_s & ~prev_q;
      2'd1:    det_s = ~filt_s & prev_q;
      default: det_s = filt_s ^ prev_q;
    endcase
  end

  // Next-state for EDGE (write-1-to-clear, a new edge beats the clear) and MASK
  always_comb begin
    edge_d = edge_q;
    mask_d = mask_q;
    if (wr_s && (address == 2'd1)) begin
      edge_d = (edge_q & ~writedata[WIDTH-1:0]) | det_s;
    end else begin
      edge_d = edge_q | det_s;
    end
    if (wr_s && (address == 2'd2)) begin
      mask_d = writedata[WIDTH-1:0];
    end else begin
      mask_d = mask_q;
    end
  end

  // Read mux, zero-extended; reserved address reads zero
  always_comb begin
    readdata_d = 32'd0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = filt_s;
      2'd1:    readdata_d[WIDTH-1:0] = edge_q;
      2'd2:    readdata_d[WIDTH-1:0] = mask_q;
      default: readdata_d = 32'd0;
    endcase
  end

  // Register state: previous filtered value, EDGE, MASK and read data
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q     <= {WIDTH{1'b0}};
      edge_q     <= {WIDTH{1'b0}};
      mask_q     <= {WIDTH{1'b0}};
      readdata_q <= 32'd0;
    end else begin
      prev_q     <= filt_s;
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  // Interrupt is a pure AND-OR of captured edges and mask
  assign irq      = |(edge_q & mask_q);

endmodule
